// File: rtl/spi_flash_byte_reader_pkg.sv
// Shared constants, FSM state type and sizing helper for the SPI flash byte reader.
package spi_flash_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam int unsigned DUMMY_CYCLES = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    FINISH
  } state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_flash_byte_reader_if.sv
// Request/response and SPI pin bundle for spi_flash_byte_reader.
interface spi_flash_byte_reader_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] address;
  logic              miso;
  logic              mosi;
  logic              sclk;
  logic              cs;
  logic [DATA_W-1:0] data_out;
  logic              done;

  // master: the reader itself; slave: control logic plus flash device.
  modport master (
    input  start, address, miso,
    output mosi, sclk, cs, data_out, done
  );

  modport slave (
    output start, address, miso,
    input  mosi, sclk, cs, data_out, done
  );
endinterface

// File: rtl/spi_flash_byte_reader_sclk_gen.sv
// SCLK divider: produces the internal mode-0 clock level plus one-cycle rise/fall strobes.
module spi_sclk_gen
  import spi_flash_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int unsigned CntW = cnt_width(CLK_DIV);

  logic [CntW-1:0] cnt_q;
  logic            lvl_q;
  logic            wrap;

  assign wrap = en && (cnt_q == CntW'(CLK_DIV - 1));

  always_comb begin
    rise_tick = wrap && !lvl_q;
    fall_tick = wrap && lvl_q;
  end

  always_ff @(posedge clk) begin
    if (!rst || !en) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
    end else if (wrap) begin
      cnt_q <= '0;
      lvl_q <= ~lvl_q;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign sclk = lvl_q;

endmodule

// File: rtl/spi_flash_byte_reader.sv
// SPI mode-0 master reading one byte from a NOR flash (READ, or FAST READ when
// SPI_FAST_READ_EN is defined). All pin outputs are registered from the FSM state.
module spi_flash_byte_reader
  import spi_flash_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  spi_flash_byte_reader_if.master  bus
);

`ifdef SPI_FAST_READ_EN
  localparam logic [7:0]  OPCODE = OP_FAST_READ;
  localparam int unsigned GAP    = DUMMY_CYCLES;
`else
  localparam logic [7:0]  OPCODE = OP_READ;
  localparam int unsigned GAP    = 0;
`endif

  localparam int unsigned TOTAL = 8 + ADDR_W + GAP + DATA_W;
  localparam int unsigned BitW  = cnt_width(TOTAL);
  localparam int unsigned DivW  = cnt_width(CLK_DIV);

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [TOTAL-1:0]  sr_q, sr_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rise_q;
  logic              cs_q, sclk_q, mosi_q, done_q;
  logic              cs_c, mosi_c, done_c;
  logic              div_done;
  logic              gen_sclk, rise_tick, fall_tick;

  spi_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (state_q == SHIFT),
    .sclk     (gen_sclk),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );

  assign div_done = (div_q == DivW'(CLK_DIV - 1));

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    rx_d    = rx_q;
    data_d  = data_q;
    cs_c    = 1'b1;
    mosi_c  = 1'b0;
    done_c  = 1'b0;

    // Outputs lag the internal level by one cycle, so sample miso one cycle after the tick.
    if (rise_q) begin
      rx_d = DATA_W'({rx_q, bus.miso});
    end

    unique case (state_q)
      IDLE: begin
        // done_q high means the FINISH cycle is still visible on the pins.
        if (bus.start && !done_q) begin
          sr_d    = {OPCODE, bus.address, {(GAP + DATA_W){1'b0}}};
          div_d   = '0;
          bit_d   = '0;
          rx_d    = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cs_c   = 1'b0;
        mosi_c = sr_q[TOTAL-1];
        if (div_done) begin
          div_d   = '0;
          state_d = SHIFT;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      SHIFT: begin
        cs_c   = 1'b0;
        mosi_c = sr_q[TOTAL-1];
        if (fall_tick) begin
          sr_d  = sr_q << 1;
          bit_d = bit_q + BitW'(1);
          if (bit_q == BitW'(TOTAL - 1)) begin
            bit_d   = '0;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        cs_c   = 1'b0;
        mosi_c = sr_q[TOTAL-1];
        if (div_done) begin
          div_d   = '0;
          state_d = FINISH;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      FINISH: begin
        done_c  = 1'b1;
        data_d  = rx_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      rx_q    <= '0;
      data_q  <= '0;
      rise_q  <= 1'b0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
      rise_q  <= rise_tick;
      cs_q    <= cs_c;
      sclk_q  <= gen_sclk;
      mosi_q  <= mosi_c;
      done_q  <= done_c;
    end
  end

  assign bus.cs       = cs_q;
  assign bus.sclk     = sclk_q;
  assign bus.mosi     = mosi_q;
  assign bus.done     = done_q;
  assign bus.data_out = data_q;

endmodule

// File: tb/tb_spi_flash_byte_reader.sv
// Bench for spi_flash_byte_reader: flash model mem[a] = a ^ 8'hA5, pin monitor, directed
// and random reads. Honours SPI_FAST_READ_EN.
module tb_spi_flash_byte_reader;

  localparam int CD = 2;
`ifdef SPI_FAST_READ_EN
  localparam int         LAT    = 66;
  localparam int         RISES  = 32;
  localparam int         CMD    = 24;
  localparam logic [7:0] EXP_OP = 8'h0B;
`else
  localparam int         LAT    = 50;
  localparam int         RISES  = 24;
  localparam int         CMD    = 16;
  localparam logic [7:0] EXP_OP = 8'h03;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_flash_byte_reader_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  spi_flash_byte_reader #(
    .CLK_DIV(CD),
    .ADDR_W (8),
    .DATA_W (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Flash model and pin monitor, sampled mid-cycle.
  int         rise_tot = 0, cs_low_tot = 0, done_tot = 0, viol_tot = 0, fcnt = 0;
  logic [15:0] cap = '0;
  logic [7:0]  op_seen = '0, addr_seen = '0, mb;
  logic        p_sclk = 1'b0, p_cs = 1'b1, p_mosi = 1'b0, p_done = 1'b0;

  always @(negedge clk) begin
    if (!bus.cs) cs_low_tot++;
    if (bus.done) done_tot++;
    if (bus.done && p_done) viol_tot++;
    if (rst && (bus.cs != p_cs) && (bus.sclk || p_sclk)) viol_tot++;
    if (!bus.cs && !p_cs && (bus.mosi != p_mosi) && !(p_sclk && !bus.sclk)) viol_tot++;
    if (!rst) begin
      fcnt     = 0;
      bus.miso = 1'b0;
    end else if (!bus.cs && p_cs) begin
      fcnt     = 0;
      bus.miso = 1'b0;
    end else if (!bus.cs) begin
      if (bus.sclk && !p_sclk) begin
        rise_tot++;
        cap = {cap[14:0], bus.mosi};
        fcnt++;
        if (fcnt == 16) begin
          op_seen   = cap[15:8];
          addr_seen = cap[7:0];
        end
      end
      if (!bus.sclk && p_sclk && fcnt >= CMD && fcnt < CMD + 8) begin
        mb       = addr_seen ^ 8'hA5;
        bus.miso = mb[7-(fcnt-CMD)];
      end
    end
    p_sclk = bus.sclk;
    p_cs   = bus.cs;
    p_mosi = bus.mosi;
    p_done = bus.done;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [7:0] a, output int n);
    @(posedge clk);
    #1;
    bus.start   = 1'b1;
    bus.address = a;
    @(posedge clk);
    #1;
    n           = cyc;
    bus.start   = 1'b0;
    bus.address = 8'($urandom);
  endtask

  task automatic wait_done(input int glitch_at, output bit seen, output int m);
    seen = 1'b0;
    m    = 0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (i == glitch_at) begin
        bus.start   = 1'b1;
        bus.address = 8'h55;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        seen = 1'b1;
        m    = cyc;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, input int glitch_at, input string tag);
    int n, m, r0, c0, d0, v0;
    bit seen;
    r0 = rise_tot;
    c0 = cs_low_tot;
    d0 = done_tot;
    v0 = viol_tot;
    issue(a, n);
    wait_done(glitch_at, seen, m);
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, m - n, 1 + LAT * CD);
    chk({tag, " data_out"}, 32'(bus.data_out), 32'(a ^ 8'hA5));
    chk({tag, " opcode"}, 32'(op_seen), 32'(EXP_OP));
    chk({tag, " address"}, 32'(addr_seen), 32'(a));
    repeat (2) @(posedge clk);
    #1;
    chk({tag, " done_pulses"}, done_tot - d0, 32'd1);
    chk({tag, " sclk_rises"}, rise_tot - r0, RISES);
    chk({tag, " cs_low_cycles"}, cs_low_tot - c0, LAT * CD);
    chk({tag, " mode0_violations"}, viol_tot - v0, 32'd0);
    chk({tag, " cs_idle"}, 32'(bus.cs), 32'd1);
  endtask

  initial begin
    int n, m, m2, n2, d0, g;
    bit seen;
    logic [7:0] a;
    bus.start   = 1'b0;
    bus.address = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset cs", 32'(bus.cs), 32'd1);
    chk("reset sclk", 32'(bus.sclk), 32'd0);
    chk("reset mosi", 32'(bus.mosi), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset data_out", 32'(bus.data_out), 32'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    do_read(8'h0A, -1, "read_0a");
    repeat (20) @(posedge clk);
    do_read(8'h0B, -1, "read_0b");
    do_read(8'h0A, 30, "ignored_start");

    // Reset during the address phase aborts the transfer.
    d0 = done_tot;
    issue(8'h0A, n);
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset cs", 32'(bus.cs), 32'd1);
    chk("midreset sclk", 32'(bus.sclk), 32'd0);
    chk("midreset data_out", 32'(bus.data_out), 32'd0);
    chk("midreset done", 32'(bus.done), 32'd0);
    rst = 1'b1;
    repeat (120) @(posedge clk);
    #1;
    chk("midreset no_done", done_tot - d0, 32'd0);
    do_read(8'h0A, -1, "after_reset");

    // start held from the done cycle: ignored first, accepted one cycle later.
    issue(8'h33, n);
    wait_done(-1, seen, m);
    chk("chain first_done", 32'(seen), 32'd1);
    chk("chain first_data", 32'(bus.data_out), 32'(8'h33 ^ 8'hA5));
    bus.start   = 1'b1;
    bus.address = 8'h44;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    n2        = cyc;
    bus.start = 1'b0;
    wait_done(-1, seen, m2);
    chk("chain second_done", 32'(seen), 32'd1);
    chk("chain accept_delay", m2 - m, 3 + LAT * CD);
    chk("chain second_data", 32'(bus.data_out), 32'(8'h44 ^ 8'hA5));
    repeat (3) @(posedge clk);

    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      a = 8'($urandom);
      g = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 90)) : -1;
      do_read(a, g, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
